// File: rtl/configurable_pe.sv
// Systolic-array processing element: signed MAC with output- or weight-stationary dataflow,
// optional saturation, a sticky overflow flag and a result-drain shift chain.
module configurable_pe #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 32,
  parameter bit SATURATE   = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         mode,
  input  logic                         clear_acc,
  input  logic                         load_w,
  input  logic signed [DATA_WIDTH-1:0] a_in,
  input  logic signed [DATA_WIDTH-1:0] b_in,
  input  logic signed [ACC_WIDTH-1:0]  psum_in,
  output logic signed [DATA_WIDTH-1:0] a_out,
  output logic signed [DATA_WIDTH-1:0] b_out,
  output logic signed [ACC_WIDTH-1:0]  psum_out,
  output logic signed [ACC_WIDTH-1:0]  result_out,
  output logic                         ovf,
  input  logic                         drain_capture,
  input  logic                         drain_shift,
  input  logic signed [ACC_WIDTH-1:0]  drain_in,
  input  logic                         drain_in_valid,
  output logic signed [ACC_WIDTH-1:0]  drain_out,
  output logic                         drain_valid
);

  localparam int PW = 2 * DATA_WIDTH;
  localparam int SW = ACC_WIDTH + 1;
  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  typedef enum logic {
    MODE_OS = 1'b0,
    MODE_WS = 1'b1
  } pe_mode_e;

  pe_mode_e                     cur_mode;
  logic signed [DATA_WIDTH-1:0] w;
  logic signed [ACC_WIDTH-1:0]  acc;
  logic signed [PW-1:0]         mul_x;
  logic signed [PW-1:0]         mul_y;
  logic signed [PW-1:0]         prod;
  logic signed [SW-1:0]         prod_ext;
  logic signed [SW-1:0]         os_sum;
  logic signed [SW-1:0]         ws_sum;
  logic signed [ACC_WIDTH-1:0]  os_next;
  logic signed [ACC_WIDTH-1:0]  ws_next;
  logic                         os_ovf;
  logic                         ws_ovf;

  // One guard bit above the accumulator: the sum is out of range exactly when the top two bits differ.
  function automatic logic signed [ACC_WIDTH-1:0] fit(input logic signed [SW-1:0] s);
    logic over;
    over = s[SW-1] ^ s[SW-2];
    if (over && SATURATE) return s[SW-1] ? ACC_MIN : ACC_MAX;
    return s[ACC_WIDTH-1:0];
  endfunction

  assign cur_mode   = pe_mode_e'(mode);
  assign result_out = acc;

  // NOTE: every always_comb output is assigned on every path, so no latch can be inferred.
  always_comb begin
    mul_x    = PW'(cur_mode == MODE_WS ? w : a_in);
    mul_y    = PW'(b_in);
    prod     = mul_x * mul_y;
    prod_ext = SW'(prod);
    os_sum   = SW'(acc) + prod_ext;
    ws_sum   = SW'(psum_in) + prod_ext;
    os_next  = fit(os_sum);
    ws_next  = fit(ws_sum);
    os_ovf   = os_sum[SW-1] ^ os_sum[SW-2];
    ws_ovf   = ws_sum[SW-1] ^ ws_sum[SW-2];
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_out       <= '0;
      b_out       <= '0;
      psum_out    <= '0;
      acc         <= '0;
      w           <= '0;
      ovf         <= 1'b0;
      drain_out   <= '0;
      drain_valid <= 1'b0;
    end else begin
      if (en) begin
        a_out <= a_in;
        b_out <= b_in;
      end

      if (en && cur_mode == MODE_OS) begin
        // A clear loads the product directly, so no add and no overflow on that cycle.
        if (clear_acc) begin
          acc <= prod_ext[ACC_WIDTH-1:0];
          ovf <= 1'b0;
        end else begin
          acc <= os_next;
          ovf <= ovf | os_ovf;
        end
      end else if (en && cur_mode == MODE_WS) begin
        psum_out <= ws_next;
        if (load_w) w <= a_in;
        if (clear_acc) begin
          acc <= '0;
          ovf <= 1'b0;
        end else begin
          ovf <= ovf | ws_ovf;
        end
      end else if (clear_acc) begin
        acc <= '0;
        ovf <= 1'b0;
      end

      // Drain chain runs regardless of en; capture takes the accumulator before this edge's update.
      if (drain_capture) begin
        drain_out   <= acc;
        drain_valid <= 1'b1;
      end else if (drain_shift) begin
        drain_out   <= drain_in;
        drain_valid <= drain_in_valid;
      end
    end
  end

endmodule

// File: doc/configurable_pe.md
CONFIGURABLE_PE -- requirements
Module: configurable_pe

Interface
REQ-001 Parameter DATA_WIDTH, default 8, signed operand width.
REQ-002 Parameter ACC_WIDTH, default 32, signed accumulator/partial-sum width; SHALL be >= 2*DATA_WIDTH.
REQ-003 Parameter SATURATE, default 1, 1 = clamp on overflow, 0 = two's-complement wrap.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 en  input  1  compute-advance enable.
REQ-007 mode  input  1  0 = output-stationary (OS), 1 = weight-stationary (WS).
REQ-008 clear_acc  input  1  start new accumulation, clear overflow flag.
REQ-009 load_w  input  1  WS weight-latch strobe.
REQ-010 a_in  input  DATA_WIDTH  signed weight from north.
REQ-011 b_in  input  DATA_WIDTH  signed activation from west.
REQ-012 psum_in  input  ACC_WIDTH  signed partial sum from north (WS).
REQ-013 a_out, b_out  output  DATA_WIDTH  registered systolic forwards south/east.
REQ-014 psum_out  output  ACC_WIDTH  registered WS partial sum to south.
REQ-015 result_out  output  ACC_WIDTH  OS accumulator value.
REQ-016 ovf  output  1  sticky overflow flag.
REQ-017 drain_capture, drain_shift  input  1 each  result-drain controls.
REQ-018 drain_in  input  ACC_WIDTH, drain_in_valid  input  1  drain chain from west neighbour.
REQ-019 drain_out  output  ACC_WIDTH, drain_valid  output  1  drain chain to east neighbour.

Function
REQ-020 With en=1: a_out<=a_in, b_out<=b_in (1-cycle latency); with en=0 both hold.
REQ-021 Product p = a_in*b_in (OS) or w*b_in (WS), full 2*DATA_WIDTH signed, sign-extended to ACC_WIDTH+1 before addition.
REQ-022 OS, en=1: acc<=clear_acc ? p : sum(acc,p); result_out=acc; psum_out holds.
REQ-023 clear_acc=1 with en=0 SHALL set acc<=0 and ovf<=0 in any mode.
REQ-024 WS, en=1, load_w=1: w<=a_in; product that cycle uses old w.
REQ-025 WS, en=1: psum_out<=sum(psum_in,p), 1-cycle latency; acc holds.
REQ-026 sum(): ACC_WIDTH+1-bit add; out of range -> SATURATE=1 clamps to +2^(ACC_WIDTH-1)-1 / -2^(ACC_WIDTH-1), SATURATE=0 keeps low ACC_WIDTH bits; either way ovf<=1 (OS and WS paths).
REQ-027 ovf sticky until clear_acc or rst; clear_acc with simultaneous overflow leaves ovf=0 (OS clear loads p, no add).
REQ-028 Mode change SHALL NOT clear acc, w, psum_out or drain state.
REQ-029 drain_capture=1: drain_out<=acc (pre-update value), drain_valid<=1.
REQ-030 drain_shift=1, drain_capture=0: drain_out<=drain_in, drain_valid<=drain_in_valid.
REQ-031 Both asserted: capture wins; neither: hold.
REQ-032 Drain logic independent of en.

Reset
REQ-033 rst=1 SHALL immediately, without clock, zero a_out, b_out, psum_out, result_out, w, drain_out, drain_valid, ovf.
REQ-034 Outputs stay zero while rst=1 regardless of other inputs; first update on first rising edge after deassertion.

Verification
REQ-035 OS, en=1: clear_acc=1 a=3 b=4, then a=-2 b=5 -> result_out 12, then 2; a_out 3 then -2 one cycle behind.
REQ-036 OS ACC_WIDTH=16: a=b=127 three cycles after clear -> 16129, 32258, then SATURATE=1: 32767 ovf=1; SATURATE=0: -17149 ovf=1.
REQ-037 WS: load_w a_in=-7, next b_in=6 psum_in=100 -> psum_out 58; a_out=-7 one cycle after load.
REQ-038 en=0 with changing inputs -> all outputs hold; clear_acc en=0 with acc=12 ovf=1 -> acc 0, ovf 0.
REQ-039 Drain: capture at acc=12 -> drain_out 12 valid 1; shift drain_in=5 valid 1 -> 5; capture+shift together -> acc value.
REQ-040 rst asserted mid-accumulation between clock edges -> all outputs 0 before next edge; held through reset.
